// File: rtl/piso_serializer.sv
// piso_serializer: LSB-first parallel-to-serial framer with optional idle gap; SERIALIZER_PARITY_EN appends an even-parity bit
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             c,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_done
);
`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             out_q, out_d, out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d, din_ready_q, din_ready_d;
  logic             accept, last;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif
  assign din_ready  = din_ready_q;
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign accept     = din_valid & din_ready_q;
  assign last       = state_q == S_SHIFT && cnt_q == CW'(FLEN - 1);
  // next state and next registered outputs; sh_q shifts right so the next bit is always sh_q[1]
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    sh_d         = sh_q;
    out_d        = 1'b0;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    din_ready_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d        = par_q;
`endif
    if ((state_q == S_IDLE || last) && accept) begin
      state_d     = S_SHIFT;
      cnt_d       = '0;
      sh_d        = din;
      out_d       = din[0];
      out_valid_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_d       = ^din;
`endif
    end else if (state_q == S_SHIFT && !last) begin
      cnt_d        = cnt_q + CW'(1);
      sh_d         = sh_q >> 1;
      out_d        = sh_q[1];
`ifdef SERIALIZER_PARITY_EN
      out_d        = cnt_q == CW'(WIDTH - 1) ? par_q : sh_q[1];
`endif
      out_valid_d  = 1'b1;
      frame_done_d = cnt_d == CW'(FLEN - 1);
      din_ready_d  = frame_done_d && GAP == 0;
    end else if (last && GAP > 0) begin
      state_d = S_GAP;
      cnt_d   = '0;
      gcnt_d  = '0;
    end else if (state_q == S_GAP && int'(gcnt_q) != GAP - 1) begin
      gcnt_d = gcnt_q + 4'd1;
    end else begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      gcnt_d      = '0;
      din_ready_d = 1'b1;
    end
  end
  // state and output registers; reset aborts any frame in progress
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      sh_q         <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      din_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      sh_q         <= sh_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      din_ready_q  <= din_ready_d;
    end
  end
`ifdef SERIALIZER_PARITY_EN
  // parity of the captured word, emitted after its last data bit
  always_ff @(posedge c or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer with GAP=0 and GAP=2 instances
module tb_piso_serializer;
  logic       c, rst;
  logic [3:0] a_din, b_din;
  logic       a_valid, b_valid;
  logic       a_ready, a_out, a_ov, a_fd;
  logic       b_ready, b_out, b_ov, b_fd;
  int         checks, errors;
  logic [3:0] q;

  piso_serializer #(.WIDTH(4), .GAP(0)) dut_a (
    .c(c), .rst(rst), .din(a_din), .din_valid(a_valid),
    .din_ready(a_ready), .out(a_out), .out_valid(a_ov), .frame_done(a_fd));

  piso_serializer #(.WIDTH(4), .GAP(2)) dut_b (
    .c(c), .rst(rst), .din(b_din), .din_valid(b_valid),
    .din_ready(b_ready), .out(b_out), .out_valid(b_ov), .frame_done(b_fd));

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_bits;
    logic [7:0] exp8;
    checks = 0; errors = 0; q = '0;
    rst = 1'b1; a_din = '0; b_din = '0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("rst_ready", a_ready, 0);
    check("rst_out", a_out, 0);
    check("rst_ov", a_ov, 0);
    check("rst_fd", a_fd, 0);
    step();
    check("rst_ready_clk", a_ready, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", a_ready, 1);
    check("b_ready_after_rst", b_ready, 1);
`ifdef SERIALIZER_PARITY_EN
    a_din = 4'b0111; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    exp8 = 8'b0001_0111;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("par_out%0d", k), a_out, exp8[k]);
      check($sformatf("par_ov%0d", k), a_ov, 1);
      check($sformatf("par_fd%0d", k), a_fd, k == 4);
      check($sformatf("par_rdy%0d", k), a_ready, k == 4);
      step();
    end
    check("par_end_ov", a_ov, 0);
`else
    a_din = 4'b1011; a_valid = 1'b1;
    step();
    a_valid = 1'b0; a_din = 4'b0000;
    exp_bits = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_out%0d", k), a_out, exp_bits[k]);
      check($sformatf("t1_ov%0d", k), a_ov, 1);
      check($sformatf("t1_fd%0d", k), a_fd, k == 3);
      check($sformatf("t1_rdy%0d", k), a_ready, k == 3);
      q = {a_out, q[3:1]};
      step();
    end
    check("t1_shreg", q, 4'b1011);
    check("t1_idle_ov", a_ov, 0);
    check("t1_idle_rdy", a_ready, 1);

    a_din = 4'hA; a_valid = 1'b1;
    step();
    exp8 = 8'b0101_1010;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_out%0d", k), a_out, exp8[k]);
      check($sformatf("t2_ov%0d", k), a_ov, 1);
      check($sformatf("t2_fd%0d", k), a_fd, k == 3 || k == 7);
      if (k == 0) a_din = 4'h5;
      if (k == 4) a_valid = 1'b0;
      step();
    end
    check("t2_end_ov", a_ov, 0);
    check("t2_end_rdy", a_ready, 1);

    a_din = 4'b0110; a_valid = 1'b1;
    step();
    exp_bits = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_out%0d", k), a_out, exp_bits[k]);
      check($sformatf("t3_ov%0d", k), a_ov, 1);
      a_din = ~a_din;
      a_valid = (k == 0 || k == 2);
      step();
    end
    check("t3_no_extra", a_ov, 0);

    b_din = 4'h3; b_valid = 1'b1;
    step();
    exp8 = 8'b1100_0011;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("g_out%0d", k), b_out, exp8[k]);
      check($sformatf("g_rdy%0d", k), b_ready, 0);
      check($sformatf("g_fd%0d", k), b_fd, k == 3);
      if (k == 0) b_din = 4'hC;
      step();
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("g_gap_ov%0d", g), b_ov, 0);
      check($sformatf("g_gap_rdy%0d", g), b_ready, 0);
      step();
    end
    check("g_idle_rdy", b_ready, 1);
    check("g_idle_ov", b_ov, 0);
    step();
    b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("g2_out%0d", k), b_out, exp8[k+4]);
      check($sformatf("g2_ov%0d", k), b_ov, 1);
      step();
    end
    step();
    check("g2_gap_rdy", b_ready, 0);
    step();
    check("g2_idle_rdy", b_ready, 1);
`endif

    a_din = 4'hF; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("r_bit0", a_out, 1);
    step();
    check("r_bit1", a_out, 1);
    rst = 1'b1;
    #1;
    check("r_out", a_out, 0);
    check("r_ov", a_ov, 0);
    check("r_fd", a_fd, 0);
    check("r_rdy", a_ready, 0);
    step();
    rst = 1'b0;
    step();
    check("r_rel_rdy", a_ready, 1);
    check("r_rel_ov", a_ov, 0);
    a_din = 4'b0010; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    exp_bits = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r_next_out%0d", k), a_out, exp_bits[k]);
      check($sformatf("r_next_ov%0d", k), a_ov, 1);
      step();
    end
    check("r_next_end_ov", a_ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
